// File: rtl/rcas_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package rcas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rcas_word.sv
// Combinational WORD_W-bit ripple-carry slice; b is inverted when sub=1.
// c_msb is the carry into the top bit, used for signed overflow on the last word.
module rcas_word #(
  parameter int WORD_W = 8
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);

  logic [WORD_W:0] c;
  logic [WORD_W-1:0] bx;

  always_comb begin
    c    = '0;
    sum  = '0;
    bx   = '0;
    c[0] = cin;
    for (int i = 0; i < WORD_W; i++) begin
      bx[i]    = b[i] ^ sub;
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout  = c[WORD_W];
  assign c_msb = c[WORD_W-1];

endmodule

// File: rtl/rcas_seq_ctrl.sv
// Sequences one shared add/sub slice over NWORDS words, LSW first, carry held in a flop.
// Result valid NWORDS edges after accept; held stable in DONE until out_ready.
module rcas_seq_ctrl
  import rcas_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int NWORDS = 4,
  localparam int N     = WORD_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef logic [NWORDS-1:0][WORD_W-1:0] words_t;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  words_t        a_q, a_d, b_q, b_d, result_q, result_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [WORD_W-1:0] slice_sum;
  logic              slice_cout;
  logic              slice_c_msb;

  rcas_word #(.WORD_W(WORD_W)) u_word (
    .a     (a_q[k_q]),
    .b     (b_q[k_q]),
    .cin   (carry_q),
    .sub   (op_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          // Subtract is a + ~b + 1; the +1 enters as the initial carry.
          carry_d = op;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[k_q] = slice_sum;
        carry_d       = slice_cout;
        k_d           = k_q + KW'(1);
        if (k_q == KW'(NWORDS - 1)) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_c_msb;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rcas_seq_ctrl.sv
// Randomized and directed bench for rcas_seq_ctrl against an integer-arithmetic model.
module tb_rcas_seq_ctrl;

  localparam int WORD_W = 8;
  localparam int NWORDS = 4;
  localparam int N      = WORD_W * NWORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  rcas_seq_ctrl #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, result} from plain unsigned/signed integer arithmetic.
  function automatic logic [33:0] model(input logic opi, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sr;
    logic [32:0] us;
    logic [31:0] r;
    logic c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (opi) begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      us = {1'b0, x} + {1'b0, y};
      r  = us[31:0];
      c  = us[32];
      sr = sx + sy;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {c, v, r};
  endfunction

  task automatic do_op(input logic opi, input logic [31:0] ai, input logic [31:0] bi,
                       input int hold, input logic push_at_hs);
    logic [33:0] exp;
    int waited;
    exp    = model(opi, ai, bi);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid = 1'b1; op = opi; a = ai; b = bi;
    @(posedge clk); #1;
    // Scramble inputs after accept; the latched operands must be used.
    in_valid = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    for (int i = 1; i <= NWORDS; i++) begin
      @(posedge clk); #1;
      check("lat_out_valid", {63'd0, out_valid}, (i == NWORDS) ? 64'd1 : 64'd0);
      check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    end
    check("result", {32'd0, result}, {32'd0, exp[31:0]});
    check("cout", {63'd0, cout}, {63'd0, exp[33]});
    check("ovf", {63'd0, ovf}, {63'd0, exp[32]});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_result", {30'd0, cout, ovf, result}, {30'd0, exp});
    end
    in_valid  = push_at_hs;
    a         = $urandom;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("hs_out_valid", {63'd0, out_valid}, 64'd0);
    check("hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("hs_result_kept", {30'd0, cout, ovf, result}, {30'd0, exp});
  endtask

  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h000000FF};

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;

    do_op(1'b0, 32'h000000FF, 32'h00000001, 0, 1'b0);
    check("dir_carry_w1", {32'd0, result}, 64'h100);
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0);
    check("dir_cout_msb", {62'd0, cout, ovf}, 64'b10);
    do_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1, 1'b0);
    check("dir_ovf_add", {30'd0, cout, ovf, result}, {30'd0, 2'b01, 32'h80000000});
    do_op(1'b1, 32'h00000064, 32'h0000001E, 0, 1'b0);
    check("dir_sub_nb", {30'd0, cout, ovf, result}, {30'd0, 2'b10, 32'h00000046});
    do_op(1'b1, 32'h00000000, 32'h00000001, 0, 1'b0);
    check("dir_sub_borrow", {30'd0, cout, ovf, result}, {30'd0, 2'b00, 32'hFFFFFFFF});

    // Backpressure with competing requests, including one during the handshake cycle.
    do_op(1'b0, 32'hDEADBEEF, 32'h01010101, 5, 1'b1);
    do_op(1'b1, 32'h12345678, 32'h87654321, 0, 1'b0);

    // Reset during the second RUN cycle.
    in_valid = 1'b1; op = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_result", {32'd0, result}, 64'd0);
    do_op(1'b0, 32'h12345678, 32'h11111111, 0, 1'b0);
    check("post_rst_add", {31'd0, cout, result}, {31'd0, 1'b0, 32'h23456789});

    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      do_op(1'($urandom), ra, rb, $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
